fnd_display_arbiter: RTL and testbench
======================================

# fnd_display_arbiter

Parametrised successor to the fixed 3-to-1 FND source mux and mode-LED decoder in the multi-sensing watch top level. Selects one of N_CH 7-segment sources ({fnd_data, fnd_com} from the watch, SR04, DHT11 and future sensors) for the single FND and drives a one-hot channel LED. Adds three behaviours the fixed mux lacks:
- timed auto-rotation between sources;
- event-driven pop-up of a sensor's display when its measurement completes;
- a blanking interval on every source change, which prevents ghosting between the two sources' scan phases.

## Interface
Parameters:
- N_CH, 4: number of display sources; legal range 2..16.
- SEL_W, 2: channel-index width; must equal max(1, clog2(N_CH)).
- DWELL_CYCLES, 100_000_000: auto-rotation period in clk cycles (1 s at 100 MHz); must be ≥ 1.
- BLANK_CYCLES, 1_000: blank interval inserted on each source change; must be ≥ 1.
- POPUP_CYCLES, 300_000_000: pop-up hold time in clk cycles; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- auto_en  in  1  1 = auto-rotate; 0 = manual select.
- sel  in  SEL_W  manual channel index; a value ≥ N_CH is treated as 0.
- popup_en  in  1  enables event pop-up.
- event_pulse  in  N_CH  per-channel one-cycle completion pulse (e.g. dist_done, dht_done).
- fnd_in  in  12*N_CH  channel k occupies [12k+11:12k] = {data[7:0], com[3:0]}.
- fnd_data  out  8  selected segment data; 8'hFF when blank.
- fnd_com  out  4  selected digit commons; 4'hF when blank (all digits off).
- active_ch  out  SEL_W  index of the displayed channel.
- ch_led  out  N_CH  one-hot of active_ch; all zeros while blank.
- switching  out  1  high during the blank interval.

## Operation
- State machine, two states: SHOW and BLANK.
- Target channel tgt, evaluated every cycle in priority order:
  1. popup_ch, if a pop-up is active;
  2. rot_ch, if auto_en = 1;
  3. sel, otherwise (clamped to 0 when ≥ N_CH).
- **Rotation**
  - Dwell counter counts only while auto_en = 1 and no pop-up is active.
  - At DWELL_CYCLES-1 the counter clears and rot_ch increments; N_CH-1 wraps to 0.
  - auto_en = 0 clears the dwell counter; rot_ch holds its value.
- **Pop-up**
  - event_pulse[k] with popup_en = 1 sets popup_ch = k and loads the pop-up timer with POPUP_CYCLES.
  - Several simultaneous pulses: the lowest index wins.
  - A pulse during an active pop-up retargets and restarts the timer.
  - The pop-up ends when the timer reaches 0.
  - popup_en = 0 cancels any active pop-up immediately; pulses are ignored while popup_en = 0.
- **SHOW → BLANK** when tgt ≠ active_ch. The blank counter loads BLANK_CYCLES.
- **BLANK**
  - Counter decrements each cycle.
  - In the last blank cycle, tgt is resampled: active_ch ← tgt and the state returns to SHOW.
  - tgt changes during BLANK do not extend the blank.
  - If tgt equals the old active_ch at the end of BLANK, the blank still completes and the same channel is restored.
- In SHOW the outputs register fnd_in[active_ch] every cycle; fnd_in is live, not latched.
- **Reset** (rst = 1, synchronous, overrides everything):
  - state SHOW; active_ch = 0; rot_ch = 0;
  - pop-up cleared; all counters 0;
  - fnd_data = 8'hFF, fnd_com = 4'hF, ch_led = 0, switching = 0.
- Reset mid-BLANK or mid-pop-up aborts the operation. The first cycle after reset shows channel 0.

## Timing
- All outputs are registered.
- Data path latency: 1 cycle from fnd_in to fnd_data/fnd_com.
- Source switch: tgt ≠ active_ch sampled at edge t gives:
  - switching = 1 and blank outputs from t+1 for exactly BLANK_CYCLES cycles;
  - the new active_ch, ch_led and channel data appear at t+1+BLANK_CYCLES.
- An event_pulse at edge t makes the pop-up active from t+1. Its switch starts at t+2 if the channel differs.
- Rotation period is DWELL_CYCLES counted cycles; blank time is included in the dwell.
- Pop-up timer counts during BLANK.

## Test plan
Use N_CH = 3, DWELL_CYCLES = 8, BLANK_CYCLES = 2, POPUP_CYCLES = 20 unless noted.
- **Reset:** hold rst 3 cycles with ch0 = 12'hC0E → during rst fnd_data = FF, fnd_com = F; 1 cycle after release fnd_data = C0, fnd_com = E, ch_led = 001, active_ch = 0.
- **Manual switch:** sel 0→2 at edge t → switching = 1 and outputs FF/F at t+1, t+2; at t+3 active_ch = 2, ch_led = 100, data = ch2; sel = 3 → channel 0 shown.
- **Auto rotation:** auto_en = 1 → active_ch sequence 0,1,2,0 with a change every 8 cycles, each change preceded by exactly 2 blank cycles; auto_en = 0 mid-dwell → falls to sel, and rot_ch resumes from its held value when re-enabled.
- **Pop-up:** auto_en = 1, event_pulse = 3'b110 on one cycle while ch0 is shown → ch1 shown (lowest index) after the blank for 20 cycles with rotation frozen; pulse[2] at cycle 10 of the pop-up → retarget to ch2 with the timer restarted; popup_en = 0 → immediate return to rotation.
- **Boundaries:** tgt toggles 0→1→0 within BLANK → blank lasts exactly 2 cycles, then ch0 is restored; rst asserted during BLANK → next cycle outputs FF/F, then ch0 shown.

Source files
------------

// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: selects one of N_CH 7-segment sources for the single FND.
// Supports manual select, timed auto-rotation and event pop-up, and inserts a
// blank interval on every source change so scan phases never overlap.
module fnd_display_arbiter #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned POPUP_CYCLES = 300_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 auto_en,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 popup_en,
  input  logic [N_CH-1:0]      event_pulse,
  input  logic [12*N_CH-1:0]   fnd_in,
  output logic [7:0]           fnd_data,
  output logic [3:0]           fnd_com,
  output logic [SEL_W-1:0]     active_ch,
  output logic [N_CH-1:0]      ch_led,
  output logic                 switching
);

  localparam int unsigned DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned PU_W = $clog2(POPUP_CYCLES + 1);

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0]  BLANK_LOAD = BL_W'(BLANK_CYCLES);
  localparam logic [PU_W-1:0]  POPUP_LOAD = PU_W'(POPUP_CYCLES);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);

  typedef enum logic {SHOW, BLANK} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  active_q, active_d;
  logic [BL_W-1:0]   blank_q, blank_d;
  logic [SEL_W-1:0]  rot_q, rot_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              pop_act_q, pop_act_d;
  logic [SEL_W-1:0]  pop_ch_q, pop_ch_d;
  logic [PU_W-1:0]   pop_tmr_q, pop_tmr_d;
  logic [7:0]        data_q, data_d;
  logic [3:0]        com_q, com_d;
  logic [N_CH-1:0]   led_q, led_d;
  logic              sw_q, sw_d;

  logic              pop_live;
  logic [SEL_W-1:0]  sel_ok;
  logic [SEL_W-1:0]  tgt;
  logic              ev_hit;
  logic [SEL_W-1:0]  ev_idx;
  logic [11:0]       src;

  // Target channel: pop-up beats rotation beats manual select
  always_comb begin
    // popup_en low cancels a pop-up in the same cycle, not one cycle later
    pop_live = pop_act_q & popup_en;
    sel_ok   = (32'(sel) < N_CH) ? sel : '0;
    if (pop_live)     tgt = pop_ch_q;
    else if (auto_en) tgt = rot_q;
    else              tgt = sel_ok;
  end

  // Dwell counter and rotation channel; frozen while a pop-up owns the display
  always_comb begin
    dwell_d = dwell_q;
    rot_d   = rot_q;
    if (!auto_en) begin
      dwell_d = '0;
    end else if (!pop_live) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        rot_d   = (rot_q == LAST_CH) ? '0 : rot_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Pop-up capture (lowest pulsing index wins) and hold timer
  always_comb begin
    ev_hit    = 1'b0;
    ev_idx    = '0;
    pop_act_d = pop_act_q;
    pop_ch_d  = pop_ch_q;
    pop_tmr_d = pop_tmr_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (event_pulse[k] && !ev_hit) begin
        ev_hit = 1'b1;
        ev_idx = SEL_W'(k);
      end
    end
    if (!popup_en) begin
      pop_act_d = 1'b0;
      pop_tmr_d = '0;
    end else if (ev_hit) begin
      pop_act_d = 1'b1;
      pop_ch_d  = ev_idx;
      pop_tmr_d = POPUP_LOAD;
    end else if (pop_act_q) begin
      pop_tmr_d = pop_tmr_q - 1'b1;
      if (pop_tmr_q == PU_W'(1)) pop_act_d = 1'b0;
    end
  end

  // FSM next state: start a blank on target change, resample target on its last cycle
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    blank_d  = blank_q;
    unique case (state_q)
      SHOW: begin
        if (tgt != active_q) begin
          state_d = BLANK;
          blank_d = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (blank_q == BL_W'(1)) begin
          state_d  = SHOW;
          active_d = tgt;
          blank_d  = '0;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // Output next values; keyed on the next state so the registered outputs line up with it
  always_comb begin
    src    = fnd_in[32'(active_d)*12 +: 12];
    data_d = 8'hFF;
    com_d  = 4'hF;
    led_d  = '0;
    sw_d   = 1'b0;
    if (state_d == SHOW) begin
      data_d = src[11:4];
      com_d  = src[3:0];
      led_d  = N_CH'(1) << active_d;
    end else begin
      sw_d = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SHOW;
      active_q <= '0;
      blank_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      blank_q  <= blank_d;
    end
  end

  // Rotation and pop-up registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q     <= '0;
      dwell_q   <= '0;
      pop_act_q <= 1'b0;
      pop_ch_q  <= '0;
      pop_tmr_q <= '0;
    end else begin
      rot_q     <= rot_d;
      dwell_q   <= dwell_d;
      pop_act_q <= pop_act_d;
      pop_ch_q  <= pop_ch_d;
      pop_tmr_q <= pop_tmr_d;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'hFF;
      com_q  <= 4'hF;
      led_q  <= '0;
      sw_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      com_q  <= com_d;
      led_q  <= led_d;
      sw_q   <= sw_d;
    end
  end

  assign fnd_data  = data_q;
  assign fnd_com   = com_q;
  assign active_ch = active_q;
  assign ch_led    = led_q;
  assign switching = sw_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter: N_CH=3, dwell 8, blank 2, pop-up 20.
module tb_fnd_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_en;
  logic [1:0]  sel;
  logic        popup_en;
  logic [2:0]  event_pulse;
  logic [35:0] fnd_in;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic [1:0]  active_ch;
  logic [2:0]  ch_led;
  logic        switching;

  logic [11:0] chv [3];
  int n_tests = 0;
  int n_fail  = 0;

  assign fnd_in = {chv[2], chv[1], chv[0]};

  always #5 clk = ~clk;

  fnd_display_arbiter #(
    .N_CH(3), .SEL_W(2), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .POPUP_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .sel(sel), .popup_en(popup_en),
    .event_pulse(event_pulse), .fnd_in(fnd_in), .fnd_data(fnd_data),
    .fnd_com(fnd_com), .active_ch(active_ch), .ch_led(ch_led), .switching(switching)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag, input int ch);
    logic [11:0] v;
    v = chv[ch];
    check({tag, "_dat"}, 32'(fnd_data), 32'(v[11:4]));
    check({tag, "_com"}, 32'(fnd_com), 32'(v[3:0]));
    check({tag, "_act"}, 32'(active_ch), 32'(ch));
    check({tag, "_led"}, 32'(ch_led), 32'(1) << ch);
    check({tag, "_sw"}, 32'(switching), 32'(0));
  endtask

  task automatic blank(input string tag, input int old_ch);
    check({tag, "_dat"}, 32'(fnd_data), 32'hFF);
    check({tag, "_com"}, 32'(fnd_com), 32'hF);
    check({tag, "_act"}, 32'(active_ch), 32'(old_ch));
    check({tag, "_led"}, 32'(ch_led), 32'(0));
    check({tag, "_sw"}, 32'(switching), 32'(1));
  endtask

  task automatic rstchk(input string tag);
    check({tag, "_dat"}, 32'(fnd_data), 32'hFF);
    check({tag, "_com"}, 32'(fnd_com), 32'hF);
    check({tag, "_act"}, 32'(active_ch), 32'(0));
    check({tag, "_led"}, 32'(ch_led), 32'(0));
    check({tag, "_sw"}, 32'(switching), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; auto_en = 1'b0; sel = 2'd0; popup_en = 1'b0; event_pulse = 3'b000;
    chv[0] = 12'hC0E; chv[1] = 12'hF9D; chv[2] = 12'hA4B;

    // reset held three cycles, then channel 0 one cycle after release
    for (int i = 0; i < 3; i++) begin tick(); rstchk("rst"); end
    rst = 1'b0;
    tick(); show("rel", 0);

    // manual switch 0 -> 2 with two blank cycles, live data, out-of-range select
    sel = 2'd2;
    tick(); blank("man_b1", 0);
    tick(); blank("man_b2", 0);
    tick(); show("man", 2);
    chv[2] = 12'h123;
    tick(); show("live", 2);
    chv[2] = 12'hA4B;
    tick(); show("live2", 2);
    sel = 2'd3;
    tick(); blank("clamp_b1", 2);
    tick(); blank("clamp_b2", 2);
    tick(); show("clamp", 0);

    // auto rotation 0,1,2,0 every 8 cycles, blank included in the dwell
    sel = 2'd0; auto_en = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); show("rot0", 0); end
    for (int m = 0; m < 3; m++) begin
      tick(); blank("rot_b1", m);
      tick(); blank("rot_b2", m);
      for (int i = 0; i < ((m == 2) ? 3 : 6); i++) begin tick(); show("rot", (m + 1) % 3); end
    end
    // auto off mid-dwell: fall back to sel, dwell cleared, rot_ch (0) held
    auto_en = 1'b0; sel = 2'd1;
    tick(); blank("aoff_b1", 0);
    tick(); blank("aoff_b2", 0);
    tick(); show("aoff", 1);
    auto_en = 1'b1;
    tick(); blank("aon_b1", 1);
    tick(); blank("aon_b2", 1);
    for (int i = 0; i < 6; i++) begin tick(); show("aon0", 0); end
    tick(); blank("aon_b3", 0);
    tick(); blank("aon_b4", 0);
    tick(); show("aon1", 1);

    // pop-up: simultaneous pulses, retarget, cancel
    rst = 1'b1;
    tick(); rstchk("rst2");
    rst = 1'b0; auto_en = 1'b1; popup_en = 1'b1; sel = 2'd0;
    tick(); show("pu_g0", 0);
    event_pulse = 3'b110;
    tick(); show("pu_g1", 0);
    event_pulse = 3'b000;
    tick(); blank("pu_b1", 0);
    tick(); blank("pu_b2", 0);
    for (int i = 0; i < 7; i++) begin tick(); show("pu_ch1", 1); end
    event_pulse = 3'b100;
    tick(); show("pu_g11", 1);
    event_pulse = 3'b000;
    tick(); blank("pu_rb1", 1);
    tick(); blank("pu_rb2", 1);
    for (int i = 0; i < 3; i++) begin tick(); show("pu_ch2", 2); end
    popup_en = 1'b0;
    tick(); blank("pu_cb1", 2);
    tick(); blank("pu_cb2", 2);
    for (int i = 0; i < 4; i++) begin tick(); show("pu_rot0", 0); end
    tick(); blank("pu_rb3", 0);
    tick(); blank("pu_rb4", 0);
    tick(); show("pu_rot1", 1);

    // pulse ignored while popup_en = 0
    event_pulse = 3'b100;
    tick(); show("ign1", 1);
    event_pulse = 3'b000;
    tick(); show("ign2", 1);
    auto_en = 1'b0; sel = 2'd1; popup_en = 1'b1;
    tick(); show("ign3", 1);

    // pop-up expiry after 20 cycles, then back to sel
    event_pulse = 3'b001;
    tick(); show("exp_p0", 1);
    event_pulse = 3'b000;
    tick(); blank("exp_b1", 1);
    tick(); blank("exp_b2", 1);
    for (int i = 0; i < 18; i++) begin tick(); show("exp_ch0", 0); end
    tick(); blank("exp_b3", 0);
    tick(); blank("exp_b4", 0);
    tick(); show("exp_back", 1);

    // target toggles away and back within blank: blank still two cycles, ch0 restored
    sel = 2'd0;
    tick(); blank("tg_q0", 1);
    tick(); blank("tg_q1", 1);
    tick(); show("tg_q2", 0);
    sel = 2'd1;
    tick(); blank("tg_r0", 0);
    sel = 2'd0;
    tick(); blank("tg_r1", 0);
    tick(); show("tg_r2", 0);

    // reset during blank aborts it
    sel = 2'd2;
    tick(); blank("rb_s0", 0);
    rst = 1'b1;
    tick(); rstchk("rb_s1");
    rst = 1'b0; sel = 2'd0;
    tick(); show("rb_s2", 0);
    tick(); show("rb_s3", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
